// File: rtl/muldiv_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter_unit
// Brief    : Iterative RV32M-style multiply/divide unit with tag pass-through
//            and flush. Multiplication is optionally single-cycle.
// Revision : 1.0
// ============================================================================
module muldiv_iter_unit #(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int         CNT_W     = $clog2(XLEN);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opd_q, opd_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                valid_q, valid_d;

    logic                w_is_div;
    logic                w_a_signed, w_b_signed;
    logic                w_neg_a, w_neg_b;
    logic [XLEN-1:0]     w_mag_a, w_mag_b;
    logic                w_div_zero, w_div_ovf;
    logic [XLEN-1:0]     w_special;
    logic [2*XLEN-1:0]   w_fast_prod;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_rem;
    logic [XLEN-1:0]     w_div_diff;
    logic                w_div_ge;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix, w_rem_fix;
    logic [XLEN-1:0]     w_fix_result;

    // Operand decode and magnitude extraction for the incoming request
    assign w_is_div   = op_i[2];
    assign w_a_signed = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
    assign w_b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                        (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_neg_a    = w_a_signed & a_i[XLEN-1];
    assign w_neg_b    = w_b_signed & b_i[XLEN-1];
    assign w_mag_a    = w_neg_a ? (-a_i) : a_i;
    assign w_mag_b    = w_neg_b ? (-b_i) : b_i;

    assign w_div_zero = (b_i == '0);
    assign w_div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                        (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    // op bit 1 distinguishes remainder from quotient among divide ops
    assign w_special  = w_div_zero ? (op_i[1] ? a_i : '1)
                                   : (op_i[1] ? '0  : a_i);

    generate
        if (FAST_MUL != 0) begin : g_fast_mul
            assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate

    // Shift-add: acc holds {partial high, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
    assign w_mul_next = acc_q[0] ? {w_mul_sum, acc_q[XLEN-1:1]}
                                 : {1'b0, acc_q[2*XLEN-1:1]};

    // Restoring divide: acc holds {remainder, dividend/quotient shift}
    assign w_div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign w_div_ge   = (w_div_rem >= {1'b0, opd_q});
    assign w_div_diff = w_div_rem[XLEN-1:0] - opd_q;
    assign w_div_next = w_div_ge ? {w_div_diff, acc_q[XLEN-2:0], 1'b1}
                                 : {w_div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    assign w_prod_fix = neg_res_q ? (-acc_q) : acc_q;
    assign w_quo_fix  = neg_res_q ? (-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    assign w_rem_fix  = neg_rem_q ? (-acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_result = '0;
        case (op_q)
            OP_MUL:                          w_fix_result = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:    w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                 w_fix_result = w_quo_fix;
            default:                         w_fix_result = w_rem_fix;
        endcase
    end

    assign ready_o = (state_q == S_IDLE) && !flush_i;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        valid_d   = valid_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_o) begin
                    op_d      = op_i;
                    tag_d     = tag_i;
                    neg_res_d = w_neg_a ^ w_neg_b;
                    neg_rem_d = w_neg_a;
                    cnt_d     = CNT_W'(XLEN-1);
                    if (w_is_div && (w_div_zero || w_div_ovf)) begin
                        result_d = w_special;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else if (w_is_div) begin
                        acc_d   = {{XLEN{1'b0}}, w_mag_a};
                        opd_d   = w_mag_b;
                        state_d = S_CALC;
                    end else if (FAST_MUL != 0) begin
                        acc_d   = w_fast_prod;
                        state_d = S_FIX;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, w_mag_b};
                        opd_d   = w_mag_a;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? w_div_next : w_mul_next;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                result_d = w_fix_result;
                valid_d  = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign tag_o    = tag_q;
    assign busy_o   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/muldiv_iter_unit.md
# muldiv_iter_unit

Parametrised iterative M-extension execution unit for the RV32IM pipeline. It replaces a fixed-width, single-cycle mul/div path with an XLEN-generic, handshaked multi-cycle engine. Features: optional fast multiplier, pass-through tag (e.g. rd address), and flush support. It sits in EX and is driven by the decoder's M-unit request (m_op_e encoding); its result feeds the WB_M_UNIT writeback path.

## Interface
- XLEN, default 32: operand/result width; must be ≥ 8 and even.
- FAST_MUL, default 1: 1 = multiplies use a registered full-width product; 0 = radix-2 shift-add over XLEN cycles.
- TAG_W, default 5: width of the pass-through tag.

Ports (clock and reset first):
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept; = (state==IDLE) && !flush_i.
- op_i  in  3  m_op_e: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- tag_i  in  TAG_W  tag, returned unchanged with the result.
- flush_i  in  1  abort any in-flight operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  result.
- tag_o  out  TAG_W  tag of the current result.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept when valid_i && ready_o; the unit latches op, operands and tag. Next state on accept:
  - Division special case (b==0, or signed overflow a==−2^(XLEN−1), b==−1 for DIV/REM) → DONE.
  - MUL* with FAST_MUL=1 → FIX, with the 2·XLEN product registered.
  - Otherwise → CALC; the iteration counter loads XLEN−1.
- CALC, divide: restoring radix-2 on operand magnitudes; one quotient bit per cycle.
- CALC, multiply (FAST_MUL=0): shift-add on magnitudes; one multiplier bit per cycle.
- CALC leaves for FIX when the counter reaches 0, i.e. exactly XLEN cycles in CALC.
- Signedness rules:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- FIX (1 cycle) applies the sign correction:
  - Product is negated over 2·XLEN bits when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection: MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Special-case results:
  - Divide by zero: quotient all ones; remainder = a.
  - Signed overflow: quotient = a; remainder = 0.
- DONE: valid_o=1. result_o and tag_o hold stable until ready_i; on ready_i the next state is IDLE.
- Flush:
  - flush_i=1 in any state → IDLE next edge; valid_o=0 from that edge onward.
  - In IDLE, flush_i blocks acceptance (ready_o=0).
  - A result in DONE flushed in the same cycle as ready_i counts as not delivered.
- Reset: rst_i=1 → IDLE next edge, overriding flush and handshakes.

## Timing
- Reset values: valid_o=0, result_o=0, tag_o=0, busy_o=0. ready_o=1 on the first cycle after reset when flush_i=0.
- Accept edge = cycle 0. valid_o first asserts in these cycles:
  - Division special case: cycle 1.
  - FAST_MUL multiply: cycle 2.
  - Iterative multiply or divide: cycle XLEN+2 (XLEN=32 → cycle 34).
- No accept while DONE. After the result handshake at edge n, ready_o=1 in cycle n+1. Peak throughput is one op per (latency+1) cycles.
- valid_o, result_o and tag_o are registered. ready_o is combinational from state and flush_i.
- Operand values on a_i/b_i after the accept edge have no effect.

## Test plan
- Multiplies, XLEN=32, both FAST_MUL settings:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - Check valid_o at cycle 2 (FAST_MUL=1) and cycle 34 (FAST_MUL=0).
- Signed divide, a=0xFFFFFFF9 (−7), b=2:
  - DIV → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU → 0x7FFFFFFC; REMU → 1.
  - valid_o at cycle 34; tag_i=5'h1A returned on tag_o.
- Division special cases:
  - DIV or DIVU 0x1234 / 0 → 0xFFFFFFFF; REM or REMU 0x1234 / 0 → 0x1234.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - All four cases: valid_o at cycle 1.
- Back-pressure: hold ready_i=0 for 10 cycles in DONE → valid_o, result_o and tag_o stable, ready_o=0. Then release ready_i → ready_o=1 the next cycle, and a new op is accepted.
- Flush: flush_i at cycle 10 of a DIV → IDLE next edge, valid_o never asserts. flush_i together with valid_i in IDLE → no accept, busy_o stays 0.
- rst_i asserted mid-CALC → all outputs at reset values next cycle. A subsequent MULHU 3 × 5 → 0 with correct latency.
